// File: rtl/clearable_ram_pkg.sv
// ---------------------------------------------------------------------------
// clearable_ram_pkg
//   Shared definitions for the clearable RAM slice:
//     - default geometry (DEF_WIDTH, DEF_ADDR_W)
//     - sweep FSM state encoding (state_t: CLEAR, IDLE)
// ---------------------------------------------------------------------------
package clearable_ram_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 14;

    // CLEAR is the reset state: the array is swept to INIT before any use.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/clearable_ram_if.sv
// ---------------------------------------------------------------------------
// clearable_ram_if
//   User-side bus of the clearable RAM.
//     in      : write data                 (master -> slave)
//     load    : write enable               (master -> slave)
//     address : read/write word address    (master -> slave)
//     clear   : one-cycle sweep request    (master -> slave)
//     out     : registered read data       (slave -> master)
//     busy    : sweep in progress          (slave -> master)
// ---------------------------------------------------------------------------
interface clearable_ram_if
    import clearable_ram_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic              clear;
    logic [WIDTH-1:0]  out;
    logic              busy;

    modport master (
        output in,
        output load,
        output address,
        output clear,
        input  out,
        input  busy
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        input  clear,
        output out,
        output busy
    );

endinterface

// File: rtl/clearable_ram_clear_sequencer.sv
// ---------------------------------------------------------------------------
// clear_sequencer
//   Two-state sweep FSM plus the sweep address counter.
//   Ports:
//     clock : sole clock
//     reset : synchronous, active-low; forces a fresh sweep from word 0
//     clear : sweep request, honoured only when idle
//     busy  : high while the sweep is running
//     cnt   : word being written by the sweep this cycle
// ---------------------------------------------------------------------------
module clear_sequencer
    import clearable_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] cnt
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                // Last word: park the counter at 0 so a later sweep
                // starts from the bottom without extra bookkeeping.
                if (cnt == {ADDR_W{1'b1}}) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (clear) begin
                    cnt_nxt   = '0;
                    state_nxt = CLEAR;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = CLEAR;
            end
        endcase
    end

    // A clear seen while sweeping never reaches the FSM: busy requests
    // fall through the CLEAR arm untouched, so the sweep cannot restart.
    assign busy = (state == CLEAR);

endmodule

// File: rtl/clearable_ram.sv
// ---------------------------------------------------------------------------
// clearable_ram
//   WIDTH x 2**ADDR_W single-port RAM with a hardware clear sweep.
//   After reset, or on a clear request while idle, every word is written
//   with INIT, one word per cycle; user accesses are blocked meanwhile.
//   Ports:
//     clock : sole clock
//     reset : synchronous, active-low
//     bus   : clearable_ram_if slave (in, load, address, clear, out, busy)
//   Read data is registered (1-cycle latency) and read-before-write.
// ---------------------------------------------------------------------------
module clearable_ram
    import clearable_ram_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter int               ADDR_W = DEF_ADDR_W,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic          clock,
    input  logic          reset,
    clearable_ram_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  out_q;
    logic              busy;
    logic [ADDR_W-1:0] cnt;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    clear_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clock (clock),
        .reset (reset),
        .clear (bus.clear),
        .busy  (busy),
        .cnt   (cnt)
    );

    // Write port mux: the sweep owns the port whenever busy. A user write
    // in the same cycle as an accepted clear is dropped. Nothing is
    // written while reset is held; the sweep begins on release.
    always_comb begin
        we    = 1'b0;
        waddr = bus.address;
        wdata = bus.in;
        if (reset) begin
            if (busy) begin
                we    = 1'b1;
                waddr = cnt;
                wdata = INIT;
            end else begin
                we = bus.load && !bus.clear;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register. It is forced to INIT on the same edges that put (or
    // keep) the FSM in CLEAR, so out reads INIT for the whole sweep,
    // including its first cycle.
    always_ff @(posedge clock) begin
        if (!reset || busy || bus.clear) begin
            out_q <= INIT;
        end else begin
            out_q <= mem[bus.address];
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy;

endmodule

// File: tb/tb_clearable_ram.sv
module tb_clearable_ram;
    import clearable_ram_pkg::*;

    localparam int          WIDTH  = 16;
    localparam int          ADDR_W = 3;
    localparam int          DEPTH  = 8;
    localparam logic [15:0] INIT   = 16'h5A5A;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    clearable_ram_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    clearable_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .INIT(INIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the memory as a plain array plus the number of
    // sweep cycles still owed. Outputs are derived from those each edge.
    logic [15:0] mm [DEPTH];
    int          sweep_left  = 0;
    logic [15:0] exp_out     = INIT;
    bit          model_valid = 0;

    always @(posedge clock) begin
        if (reset === 1'b0) begin
            sweep_left  = DEPTH;
            exp_out     = INIT;
            model_valid = 1;
        end else if (model_valid) begin
            if (sweep_left > 0) begin
                mm[DEPTH - sweep_left] = INIT;
                sweep_left--;
                exp_out = INIT;
            end else if (bus.clear) begin
                sweep_left = DEPTH;
                exp_out    = INIT;
            end else begin
                exp_out = mm[bus.address];
                if (bus.load) mm[bus.address] = bus.in;
            end
        end
        #1;
        if (model_valid) begin
            check("model_busy", {31'b0, bus.busy}, {31'b0, sweep_left > 0});
            check("model_out", {16'b0, bus.out}, {16'b0, exp_out});
        end
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input bit l, input int a, input logic [15:0] d, input bit c);
        @(negedge clock);
        reset       = 1'b1;
        bus.load    = l;
        bus.address = 3'(a);
        bus.in      = d;
        bus.clear   = c;
    endtask

    task automatic write(input int a, input logic [15:0] d);
        drive(1'b1, a, d, 1'b0);
        tick();
    endtask

    task automatic read_check(input int a, input logic [15:0] e, input string name);
        drive(1'b0, a, 16'h0000, 1'b0);
        tick();
        check(name, {16'b0, bus.out}, {16'b0, e});
    endtask

    // Runs cycles until busy drops. clear is pulsed at cycles clr_a/clr_b,
    // reset held low at rst_at, and a user write (addr 2, data 0001) is
    // offered at load_at. n = busy cycles since the latest start event,
    // tot = all busy cycles seen.
    task automatic sweep(input int clr_a, input int clr_b, input int rst_at,
                         input int load_at, output int n, output int tot);
        bit done = 0;
        n   = 0;
        tot = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            reset       = (k == rst_at) ? 1'b0 : 1'b1;
            bus.clear   = (k == clr_a) || (k == clr_b);
            bus.load    = (k == load_at);
            bus.address = 3'd2;
            bus.in      = 16'h0001;
            tick();
            if (!bus.busy) begin
                done = 1;
                break;
            end
            if (k == rst_at) n = 0;
            n++;
            tot++;
        end
        if (!done) check("sweep_timeout", 32'd1, 32'd0);
    endtask

    int n, tot;

    initial begin
        reset       = 1'b0;
        bus.load    = 1'b0;
        bus.address = '0;
        bus.in      = '0;
        bus.clear   = 1'b0;

        // First reset cycle, then the second one inside sweep().
        tick();
        check("reset_busy", {31'b0, bus.busy}, 32'd1);
        check("reset_out", {16'b0, bus.out}, {16'b0, INIT});
        @(negedge clock);
        sweep(-1, -1, 1, -1, n, tot);
        check("reset_sweep_len", n, 32'd8);
        for (int a = 0; a < DEPTH; a++) read_check(a, INIT, "post_reset_read");

        // Plain write/read.
        write(3, 16'h1234);
        read_check(3, 16'h1234, "rd_addr3");
        read_check(4, INIT, "rd_addr4");

        // Read-before-write on the same address.
        drive(1'b1, 5, 16'hBEEF, 1'b0);
        tick();
        check("rbw_old", {16'b0, bus.out}, {16'b0, INIT});
        read_check(5, 16'hBEEF, "rbw_new");

        // Fill, clear with a user write offered mid-sweep.
        for (int a = 0; a < DEPTH; a++) write(a, 16'hFFFF);
        read_check(6, 16'hFFFF, "fill_rd6");
        sweep(1, -1, -1, 4, n, tot);
        check("clear_sweep_len", n, 32'd8);
        for (int a = 0; a < DEPTH; a++) read_check(a, INIT, "post_clear_read");

        // Access in the first idle cycle after a sweep.
        write(7, 16'h0F0F);
        sweep(1, -1, -1, -1, n, tot);
        write(1, 16'hABCD);
        read_check(1, 16'hABCD, "first_idle_write");
        read_check(7, INIT, "first_idle_swept");

        // Clear in same cycle as load: load is dropped.
        write(0, 16'h1111);
        drive(1'b1, 0, 16'h2222, 1'b1);
        tick();
        drive(1'b0, 0, 16'h0, 1'b0);
        for (int k = 0; k < 20 && bus.busy; k++) tick();
        read_check(0, INIT, "clear_drops_load");

        // Second clear pulse during the sweep does not extend it.
        sweep(1, 3, -1, -1, n, tot);
        check("reclear_sweep_len", n, 32'd8);

        // Reset at cycle 4 of a sweep restarts it.
        write(5, 16'h7777);
        sweep(1, -1, 4, -1, n, tot);
        check("rst_mid_len", n, 32'd8);
        check("rst_mid_total", tot, 32'd11);
        read_check(5, INIT, "rst_mid_read5");

        drive(1'b0, 0, 16'h0, 1'b0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clearable_ram.md
CLEARABLE_RAM -- requirements
Module: clearable_ram

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 14, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter INIT, default 0 (WIDTH bits), value written to every word by a clear sweep.
REQ-004 clock  input  1  sole clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only at posedge clock.
REQ-006 in  input  WIDTH  write data.
REQ-007 load  input  1  write enable for mem[address].
REQ-008 address  input  ADDR_W  read/write word address.
REQ-009 clear  input  1  single-cycle request to start a clear sweep.
REQ-010 out  output  WIDTH  registered read data.
REQ-011 busy  output  1  high while a clear sweep is in progress.

Function
REQ-012 The block SHALL implement a two-state FSM: CLEAR (sweep in progress) and IDLE (normal access).
REQ-013 In CLEAR, the block SHALL write INIT to mem[cnt] each cycle, cnt being an ADDR_W-bit counter starting at 0 and incrementing by 1.
REQ-014 When cnt == DEPTH-1 in CLEAR, the block SHALL write the last word, hold cnt at 0, and enter IDLE next cycle; a sweep takes exactly DEPTH cycles.
REQ-015 busy SHALL equal 1 exactly when the FSM is in CLEAR.
REQ-016 In CLEAR, load, address, in and clear SHALL be ignored; no user write takes effect, and out SHALL hold INIT.
REQ-017 In IDLE, with load=1, the block SHALL write in to mem[address] at the posedge.
REQ-018 In IDLE, out SHALL load mem[address] at every posedge (1-cycle read latency).
REQ-019 If load=1 and a read hits the same address in the same cycle, out SHALL return the old contents (read-before-write); the new value is visible on the next read.
REQ-020 In IDLE, clear=1 SHALL enter CLEAR next cycle with cnt=0; any load in that same cycle SHALL be ignored.
REQ-021 clear asserted while busy=1 SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-022 The first IDLE cycle after a sweep SHALL accept reads and writes normally; out shows mem[address] one cycle later.
REQ-023 Address arithmetic SHALL be modulo DEPTH; no out-of-range address exists.

Reset
REQ-024 While reset=0 at a posedge, the FSM SHALL enter CLEAR, cnt SHALL be 0, busy SHALL be 1, out SHALL be INIT.
REQ-025 The first INIT write (mem[0]) SHALL occur at the first posedge with reset=1; busy falls DEPTH cycles after reset release.
REQ-026 Reset asserted mid-sweep or mid-access SHALL restart the sweep from address 0; memory contents need not be preserved.
REQ-027 The memory array itself SHALL have no reset beyond the sweep.

Structure
REQ-028 The FSM state encoding (CLEAR, IDLE) SHALL be defined once as named constants in the shared memory package, beside the default WIDTH/ADDR_W values.
REQ-029 The storage SHALL be a behavioural WIDTH x DEPTH array with one write port and one synchronous read port, mappable to block RAM.
REQ-030 The counter and FSM SHALL reside in one sub-module, clear_sequencer (inputs clock, reset, clear; outputs busy, cnt); the top-level clearable_ram SHALL select the write port between sequencer and user.

Verification (bench uses WIDTH=16, ADDR_W=3, INIT=16'h5A5A)
REQ-031 Reset low 2 cycles, then high -> busy=1 for exactly 8 cycles, then 0; reads of addresses 0..7 return 16'h5A5A.
REQ-032 IDLE: write 16'h1234 to address 3, then read address 3 -> out=16'h1234 one cycle after the read address is applied; address 4 still 16'h5A5A.
REQ-033 Same cycle load=1, address=5, in=16'hBEEF -> out in the next cycle = 16'h5A5A (old); following read of address 5 = 16'hBEEF.
REQ-034 Fill all words with 16'hFFFF, pulse clear -> busy=1 for 8 cycles; load=1 (in=16'h0001, address 2) during busy is dropped; all reads afterwards = 16'h5A5A.
REQ-035 Pulse clear again at cycle 3 of a sweep -> busy still falls at cycle 8 of the original sweep.
REQ-036 Reset low at cycle 4 of a sweep -> out=16'h5A5A, cnt restarts at 0, busy stays 1 for 8 cycles after reset release.
